// File: rtl/cnn_frame_pooler_pkg.sv
// Shared types for the CNN frame pooler: FSM states, pooling modes and a width helper.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        PAD   = 2'd2,
        READY = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_AVG = 2'd0,
        MODE_BIN = 2'd1,
        MODE_INV = 2'd2,
        MODE_RSV = 2'd3
    } mode_e;

    // Index width for an n-entry array, never less than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_frame_pooler_if.sv
// Pixel-stream input and output-buffer write port of the CNN frame pooler.
interface cnn_frame_pooler_if #(
    parameter int CAM_D_SIZE = 8,
    parameter int ACC_D_SIZE = 14,
    parameter int AW         = 10
);
    logic                  pix_valid;
    logic                  pix_sof;
    logic [CAM_D_SIZE-1:0] pix_data;
    logic [1:0]            mode;
    logic [ACC_D_SIZE-1:0] threshold;
    logic                  hold;
    logic                  consume;
    logic                  out_we;
    logic [AW-1:0]         out_addr;
    logic [7:0]            out_data;
    logic                  frame_ready;
    logic                  busy;
    logic                  sof_err;

    modport master (
        output pix_valid, pix_sof, pix_data, mode, threshold, hold, consume,
        input  out_we, out_addr, out_data, frame_ready, busy, sof_err
    );

    modport slave (
        input  pix_valid, pix_sof, pix_data, mode, threshold, hold, consume,
        output out_we, out_addr, out_data, frame_ready, busy, sof_err
    );
endinterface

// File: rtl/cnn_frame_pooler_pool_row_acc.sv
// One row of per-block pixel accumulators; sum_o is the running block sum including pix_i.
module pool_row_acc #(
    parameter int CNN_INPUT_WIDTH = 28,
    parameter int CAM_D_SIZE      = 8,
    parameter int ACC_D_SIZE      = 14,
    parameter int CXW             = 5
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  load_i,
    input  logic [CXW-1:0]        cx_i,
    input  logic [CAM_D_SIZE-1:0] pix_i,
    output logic [ACC_D_SIZE-1:0] sum_o
);
    logic [ACC_D_SIZE-1:0] acc_q [CNN_INPUT_WIDTH];

    always_comb begin
        sum_o = load_i ? ACC_D_SIZE'(pix_i) : acc_q[cx_i] + ACC_D_SIZE'(pix_i);
    end

    always_ff @(posedge clk_i) begin
        if (en_i) acc_q[cx_i] <= sum_o;
    end
endmodule

// File: rtl/cnn_frame_pooler.sv
// Pools an ROI of a raster camera frame into a padded CNN input grid, writing one cell per cycle.
module cnn_frame_pooler
    import cnn_pkg::*;
#(
    parameter int screenwidth      = 640,
    parameter int screenheight     = 480,
    parameter int REC_WIDTH        = 8,
    parameter int REC_HEIGHT       = 8,
    parameter int CNN_INPUT_WIDTH  = 28,
    parameter int CNN_INPUT_HEIGHT = 28,
    parameter int CNN_INPUT_PAD    = 2,
    parameter int CAM_D_SIZE       = 8,
    parameter int ROI_X0           = 208,
    parameter int ROI_Y0           = 128
) (
    input  logic              clk24,
    input  logic              rst,
    cnn_frame_pooler_if.slave bus
);
    localparam int ACC_D_SIZE = $clog2(REC_WIDTH * REC_HEIGHT) + CAM_D_SIZE;
    localparam int OUT_W      = CNN_INPUT_WIDTH + 2 * CNN_INPUT_PAD;
    localparam int OUT_H      = CNN_INPUT_HEIGHT + 2 * CNN_INPUT_PAD;
    localparam int AW         = $clog2(OUT_W * OUT_H);
    localparam int XW  = $clog2(screenwidth + 1);
    localparam int YW  = $clog2(screenheight + 1);
    localparam int CXW = idx_w(CNN_INPUT_WIDTH);
    localparam int CYW = idx_w(CNN_INPUT_HEIGHT);
    localparam int PCW = idx_w(OUT_W);
    localparam int PRW = idx_w(OUT_H);
    localparam int LW  = $clog2(REC_WIDTH);
    localparam int LH  = $clog2(REC_HEIGHT);

    localparam logic [XW-1:0]  X_LAST  = XW'(screenwidth - 1);
    localparam logic [YW-1:0]  Y_LAST  = YW'(screenheight - 1);
    localparam logic [XW-1:0]  RX0     = XW'(ROI_X0);
    localparam logic [XW-1:0]  RX1     = XW'(ROI_X0 + CNN_INPUT_WIDTH * REC_WIDTH);
    localparam logic [YW-1:0]  RY0     = YW'(ROI_Y0);
    localparam logic [YW-1:0]  RY1     = YW'(ROI_Y0 + CNN_INPUT_HEIGHT * REC_HEIGHT);
    localparam logic [XW-1:0]  XMASK   = XW'(REC_WIDTH - 1);
    localparam logic [YW-1:0]  YMASK   = YW'(REC_HEIGHT - 1);
    localparam logic [PCW-1:0] PC_LAST = PCW'(OUT_W - 1);
    localparam logic [PCW-1:0] PC_SKIP = PCW'(CNN_INPUT_PAD - 1);
    localparam logic [PCW-1:0] PC_JUMP = PCW'(OUT_W - CNN_INPUT_PAD);
    localparam logic [PRW-1:0] PR_LAST = PRW'(OUT_H - 1);
    localparam logic [PRW-1:0] PR_TOP  = PRW'(CNN_INPUT_PAD);
    localparam logic [PRW-1:0] PR_BOT  = PRW'(OUT_H - CNN_INPUT_PAD);

    if ((REC_WIDTH & (REC_WIDTH - 1)) != 0 || (REC_HEIGHT & (REC_HEIGHT - 1)) != 0) begin : g_bad_block
        $error("REC_WIDTH and REC_HEIGHT must be powers of two");
    end

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d, mode_eff;
    logic [ACC_D_SIZE-1:0] thr_q, thr_d, thr_eff, sum;
    logic [XW-1:0]         x_q, x_d, px, rx;
    logic [YW-1:0]         y_q, y_d, py, ry;
    logic [PCW-1:0]        pc_q, pc_d;
    logic [PRW-1:0]        pr_q, pr_d;
    logic [CXW-1:0]        cx;
    logic [CYW-1:0]        cy;
    logic                  start, accept, in_roi, blk_first, blk_last;
    logic [AW-1:0]         blk_addr, pad_addr, out_addr_q, out_addr_d;
    logic [7:0]            blk_res, out_data_q, out_data_d;
    logic                  out_we_q, out_we_d, sof_err_q, sof_err_d;

    // A sof pixel is always treated as pixel (0,0) with the newly presented mode/threshold.
    always_comb begin
        start     = bus.pix_valid && bus.pix_sof &&
                    ((state_q == IDLE && !bus.hold) || state_q == ACCUM);
        accept    = start || (bus.pix_valid && state_q == ACCUM);
        px        = start ? '0 : x_q;
        py        = start ? '0 : y_q;
        mode_eff  = start ? mode_e'(bus.mode) : mode_q;
        thr_eff   = start ? bus.threshold : thr_q;
        rx        = px - RX0;
        ry        = py - RY0;
        cx        = CXW'(rx >> LW);
        cy        = CYW'(ry >> LH);
        in_roi    = accept && px >= RX0 && px < RX1 && py >= RY0 && py < RY1;
        blk_first = ((rx & XMASK) == '0) && ((ry & YMASK) == '0);
        blk_last  = ((rx & XMASK) == XMASK) && ((ry & YMASK) == YMASK);
        blk_addr  = AW'((32'(cy) + CNN_INPUT_PAD) * OUT_W + 32'(cx) + CNN_INPUT_PAD);
        pad_addr  = AW'(32'(pr_q) * OUT_W + 32'(pc_q));
    end

    pool_row_acc #(
        .CNN_INPUT_WIDTH(CNN_INPUT_WIDTH),
        .CAM_D_SIZE     (CAM_D_SIZE),
        .ACC_D_SIZE     (ACC_D_SIZE),
        .CXW            (CXW)
    ) u_row_acc (
        .clk_i (clk24),
        .en_i  (in_roi),
        .load_i(blk_first),
        .cx_i  (cx),
        .pix_i (bus.pix_data),
        .sum_o (sum)
    );

    always_comb begin
        case (mode_eff)
            MODE_BIN: blk_res = (sum >= thr_eff) ? 8'hFF : 8'h00;
            MODE_INV: blk_res = (sum >= thr_eff) ? 8'h00 : 8'hFF;
            default:  blk_res = 8'(sum >> (LW + LH));
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        thr_d      = thr_q;
        x_d        = x_q;
        y_d        = y_q;
        pc_d       = pc_q;
        pr_d       = pr_q;
        out_we_d   = 1'b0;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        sof_err_d  = 1'b0;
        if (start) begin
            state_d   = ACCUM;
            mode_d    = mode_e'(bus.mode);
            thr_d     = bus.threshold;
            sof_err_d = (state_q == ACCUM) && (x_q != '0 || y_q != '0);
        end
        if (accept) begin
            if (px == X_LAST) begin
                x_d = '0;
                y_d = (py == Y_LAST) ? '0 : py + YW'(1);
            end else begin
                x_d = px + XW'(1);
                y_d = py;
            end
            if (px == X_LAST && py == Y_LAST) begin
                state_d = (CNN_INPUT_PAD > 0) ? PAD : READY;
                pc_d    = '0;
                pr_d    = '0;
            end
            if (in_roi && blk_last) begin
                out_we_d   = 1'b1;
                out_addr_d = blk_addr;
                out_data_d = blk_res;
            end
        end
        case (state_q)
            PAD: begin
                out_we_d   = 1'b1;
                out_addr_d = pad_addr;
                out_data_d = (mode_q == MODE_INV) ? 8'hFF : 8'h00;
                // Interior rows jump straight from the left border strip to the right one.
                if (pr_q == PR_LAST && pc_q == PC_LAST) begin
                    state_d = READY;
                end else if (pc_q == PC_LAST) begin
                    pc_d = '0;
                    pr_d = pr_q + PRW'(1);
                end else if (pr_q >= PR_TOP && pr_q < PR_BOT && pc_q == PC_SKIP) begin
                    pc_d = PC_JUMP;
                end else begin
                    pc_d = pc_q + PCW'(1);
                end
            end
            READY: if (bus.consume) state_d = IDLE;
            default: ;
        endcase
    end

    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= MODE_AVG;
            thr_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            pc_q       <= '0;
            pr_q       <= '0;
            out_we_q   <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            sof_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            thr_q      <= thr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            pc_q       <= pc_d;
            pr_q       <= pr_d;
            out_we_q   <= out_we_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            sof_err_q  <= sof_err_d;
        end
    end

    assign bus.out_we      = out_we_q;
    assign bus.out_addr    = out_addr_q;
    assign bus.out_data    = out_data_q;
    assign bus.sof_err     = sof_err_q;
    assign bus.frame_ready = (state_q == READY);
    assign bus.busy        = (state_q == ACCUM) || (state_q == PAD);
endmodule

// File: tb/tb_cnn_frame_pooler.sv
// Directed bench: 16x16 frame, 2x2 blocks, 4x4 grid, 1-cell border, ROI origin (4,4).
module tb_cnn_frame_pooler;
    logic clk24 = 1'b0;
    logic rst   = 1'b0;

    always #5 clk24 = ~clk24;

    cnn_frame_pooler_if #(.CAM_D_SIZE(8), .ACC_D_SIZE(10), .AW(6)) bus ();

    cnn_frame_pooler #(
        .screenwidth     (16),
        .screenheight    (16),
        .REC_WIDTH       (2),
        .REC_HEIGHT      (2),
        .CNN_INPUT_WIDTH (4),
        .CNN_INPUT_HEIGHT(4),
        .CNN_INPUT_PAD   (1),
        .CAM_D_SIZE      (8),
        .ROI_X0          (4),
        .ROI_Y0          (4)
    ) dut (
        .clk24(clk24),
        .rst  (rst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int step_idx = 0;
    int sof_cnt  = 0;
    int sof_at   = -1;
    int restart_idx;
    logic [5:0] wa[$];
    logic [7:0] wd[$];
    logic [5:0] ea[$];
    logic [7:0] ed[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then record outputs at the next falling edge.
    task automatic step(input logic v, input logic s, input logic [7:0] d);
        bus.pix_valid = v;
        bus.pix_sof   = s;
        bus.pix_data  = d;
        @(posedge clk24);
        @(negedge clk24);
        step_idx++;
        if (bus.out_we === 1'b1) begin
            wa.push_back(bus.out_addr);
            wd.push_back(bus.out_data);
        end
        if (bus.sof_err === 1'b1) begin
            sof_cnt++;
            sof_at = step_idx;
        end
    endtask

    function automatic logic [7:0] pixval(input int kind, input int x);
        if (kind == 0) return 8'd100;
        if (x >= 4 && x <= 7) return 8'd200;
        if (x >= 8 && x <= 11) return 8'd10;
        return 8'd0;
    endfunction

    // Mode/threshold are scrambled after the sof pixel so only latched values give the right result.
    task automatic send_frame(input int kind, input logic [1:0] m, input logic [9:0] th);
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                if (x == 0 && y == 0) begin
                    bus.mode      = m;
                    bus.threshold = th;
                end
                step(1'b1, (x == 0 && y == 0), pixval(kind, x));
                if (x == 0 && y == 0) begin
                    bus.mode      = ~m;
                    bus.threshold = th + 10'd500;
                end
            end
        end
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
    endtask

    task automatic expect_frame(input int kind, input logic [1:0] m, input int th);
        int sum;
        logic [7:0] v;
        ea.delete();
        ed.delete();
        for (int cy = 0; cy < 4; cy++) begin
            for (int cx = 0; cx < 4; cx++) begin
                sum = (kind == 0) ? 400 : ((cx < 2) ? 800 : 40);
                if (m == 2'd1)      v = (sum >= th) ? 8'hFF : 8'h00;
                else if (m == 2'd2) v = (sum >= th) ? 8'h00 : 8'hFF;
                else                v = 8'(sum / 4);
                ea.push_back(6'((cy + 1) * 6 + cx + 1));
                ed.push_back(v);
            end
        end
        for (int a = 0; a < 36; a++) begin
            if (a < 6 || a >= 30 || a % 6 == 0 || a % 6 == 5) begin
                ea.push_back(6'(a));
                ed.push_back((m == 2'd2) ? 8'hFF : 8'h00);
            end
        end
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, 32'(wa.size()), 32'(ea.size()));
        for (int i = 0; i < ea.size(); i++) begin
            if (i < wa.size()) begin
                check($sformatf("%s_addr%0d", tag, i), 32'(wa[i]), 32'(ea[i]));
                check($sformatf("%s_data%0d", tag, i), 32'(wd[i]), 32'(ed[i]));
            end
        end
        wa.delete();
        wd.delete();
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.frame_ready !== 1'b1 && n < 100) begin
            step(1'b0, 1'b0, 8'd0);
            n++;
        end
        check({tag, "_ready"}, 32'(bus.frame_ready), 32'd1);
    endtask

    task automatic do_consume(input string tag);
        bus.consume = 1'b1;
        step(1'b0, 1'b0, 8'd0);
        bus.consume = 1'b0;
        check({tag, "_released"}, 32'(bus.frame_ready), 32'd0);
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_data  = '0;
        bus.mode      = '0;
        bus.threshold = '0;
        bus.hold      = 1'b0;
        bus.consume   = 1'b0;

        #1 rst = 1'b1;
        #2;
        check("rst_we",    32'(bus.out_we),      32'd0);
        check("rst_addr",  32'(bus.out_addr),    32'd0);
        check("rst_data",  32'(bus.out_data),    32'd0);
        check("rst_ready", 32'(bus.frame_ready), 32'd0);
        check("rst_busy",  32'(bus.busy),        32'd0);
        check("rst_soferr", 32'(bus.sof_err),    32'd0);
        repeat (2) @(negedge clk24);
        rst = 1'b0;

        // Constant 100, averaging: interior 100, border 0.
        send_frame(0, 2'd0, 10'd0);
        check("A_busy", 32'(bus.busy), 32'd1);
        wait_ready("A");
        expect_frame(0, 2'd0, 0);
        check_writes("A");
        do_consume("A");

        // Split ROI, binarize at 400: left columns FF, right 00.
        send_frame(1, 2'd1, 10'd400);
        wait_ready("B");
        expect_frame(1, 2'd1, 400);
        check_writes("B");
        do_consume("B");

        // Same pattern inverted: left 00, right FF, border FF.
        send_frame(1, 2'd2, 10'd400);
        wait_ready("C");
        expect_frame(1, 2'd2, 400);
        check_writes("C");
        do_consume("C");

        // Restart mid-frame at pixel (3,6) with a different mode.
        bus.mode      = 2'd2;
        bus.threshold = 10'd400;
        for (int p = 0; p < 6 * 16 + 3; p++) step(1'b1, p == 0, pixval(1, p % 16));
        check("S_partial_count", 32'(wa.size()), 32'd4);
        wa.delete();
        wd.delete();
        sof_cnt     = 0;
        restart_idx = step_idx + 1;
        send_frame(0, 2'd0, 10'd0);
        check("S_soferr_count", 32'(sof_cnt), 32'd1);
        check("S_soferr_cycle", 32'(sof_at), 32'(restart_idx));
        wait_ready("S");
        expect_frame(0, 2'd0, 0);
        check_writes("S");
        do_consume("S");

        // Frame offered under hold is refused.
        bus.hold = 1'b1;
        send_frame(0, 2'd0, 10'd0);
        repeat (3) step(1'b0, 1'b0, 8'd0);
        bus.hold = 1'b0;
        check("H_busy",  32'(bus.busy),        32'd0);
        check("H_ready", 32'(bus.frame_ready), 32'd0);
        ea.delete();
        ed.delete();
        check_writes("H");

        send_frame(1, 2'd0, 10'd0);
        wait_ready("H2");
        expect_frame(1, 2'd0, 0);
        check_writes("H2");

        // A frame arriving while READY is ignored.
        send_frame(0, 2'd2, 10'd0);
        repeat (3) step(1'b0, 1'b0, 8'd0);
        check("H2_still_ready", 32'(bus.frame_ready), 32'd1);
        check("H2_idle_busy",   32'(bus.busy),        32'd0);
        ea.delete();
        ed.delete();
        check_writes("H2_ignored");
        do_consume("H2");

        // Reset while padding.
        send_frame(0, 2'd0, 10'd0);
        repeat (3) step(1'b0, 1'b0, 8'd0);
        check("R_pad_we",   32'(bus.out_we), 32'd1);
        check("R_pad_busy", 32'(bus.busy),   32'd1);
        #2 rst = 1'b1;
        #1;
        check("R_rst_we",    32'(bus.out_we),      32'd0);
        check("R_rst_ready", 32'(bus.frame_ready), 32'd0);
        check("R_rst_busy",  32'(bus.busy),        32'd0);
        @(negedge clk24);
        rst = 1'b0;
        wa.delete();
        wd.delete();
        repeat (5) step(1'b1, 1'b0, 8'd50);
        check("R_idle_busy",  32'(bus.busy),        32'd0);
        check("R_idle_ready", 32'(bus.frame_ready), 32'd0);
        ea.delete();
        ed.delete();
        check_writes("R_idle");

        send_frame(0, 2'd0, 10'd0);
        wait_ready("R2");
        expect_frame(0, 2'd0, 0);
        check_writes("R2");
        do_consume("R2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
